rr_hr_monitor: RTL and testbench
================================

// Module: rr_hr_monitor
// PURPOSE
//  Downstream of alg_core: consumes each new RR period (in samples at ACQUISITION_RATE) and converts it to heart rate.
//  Conversion: HR = 60*ACQUISITION_RATE / rr, computed by a sequential divider.
//  Keeps a moving average over HR_NAVG beats, plus min/max since last clear; results feed uart_regs for readout.
// PARAMETERS
//  CTR_WIDTH        32    width of i_rr_period (matches alg_core counter)
//  ACQUISITION_RATE 360   sample rate [Hz]; numerator K = 60*ACQUISITION_RATE = 21600
//  HR_WIDTH         9     width of bpm values (max 300)
//  HR_NAVG          8     moving-average depth, power of 2, >=2
//  RR_MIN           72    shortest accepted rr [samples] (300 bpm)
//  RR_MAX           1080  longest accepted rr [samples] (20 bpm)
// PORTS
//  i_clk              in   1         system clock (100 MHz)
//  i_nrst             in   1         async reset, active low
//  i_ce               in   1         enable; low = new rr ignored, in-flight division completes
//  i_clr              in   1         sync clear of statistics and average window
//  i_rr_period        in   CTR_WIDTH RR interval from alg_core
//  i_rr_period_upd    in   1         1-cycle strobe, i_rr_period valid
//  o_hr_bpm           out  HR_WIDTH  last heart rate
//  o_hr_valid         out  1         1-cycle strobe, o_hr_bpm/avg/min/max updated
//  o_hr_avg           out  HR_WIDTH  window sum >> log2(HR_NAVG)
//  o_avg_valid        out  1         high once HR_NAVG beats accumulated since clear
//  o_hr_min/o_hr_max  out  HR_WIDTH  extremes since clear
//  o_busy             out  1         FSM not in IDLE
//  o_rr_invalid       out  1         1-cycle strobe: rr outside [RR_MIN,RR_MAX]
//  o_drop             out  1         1-cycle strobe: strobe arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0 except o_hr_min = all ones; FSM IDLE; window empty; sum 0.
//  FSM IDLE->DIV->UPDATE->IDLE.
//  IDLE: strobe & i_ce:
//   - rr in range: latch rr, go DIV.
//   - rr out of range: o_rr_invalid next cycle, stay IDLE, state untouched.
//  DIV: restoring division, one quotient bit per cycle, DIV_STEPS = $clog2(K+rr_max/2+1) = 15 cycles.
//   - Divisor truncated to $clog2(RR_MAX+1) bits after range check.
//  UPDATE: o_hr_bpm <= quotient; window write at wr_ptr (wraps modulo HR_NAVG); sum += new - evicted.
//   - Evicted value is 0 while filling.
//   - min/max update; fill count saturates at HR_NAVG -> o_avg_valid.
//  Latency: o_hr_valid exactly DIV_STEPS+2 cycles after the cycle the strobe was sampled.
//  o_hr_avg is 0 until o_avg_valid. Sum width HR_WIDTH+log2(HR_NAVG); no overflow possible.
//  Strobe while busy: ignored, o_drop pulses next cycle; current result unaffected.
//  i_clr (highest priority, any state):
//   - window/sum/count/min/max/avg to reset values; FSM -> IDLE.
//   - In-flight division aborted, no o_hr_valid; o_hr_bpm retained.
//  Strobe in same cycle as i_clr: ignored (no o_drop).
//  Async reset mid-division: immediate reset values, no strobe afterwards.
// CONFIGURATION
//  HR_ROUND_EN defined: numerator K + (rr>>1), result rounded to nearest bpm.
//  HR_ROUND_EN undefined: numerator K, result truncated. Latency identical in both.
// STRUCTURE
//  alg_pkg gains: HR_WIDTH, RR_MIN, RR_MAX, HR_NAVG constants; typedef hr_value; enum hr_state_t {HR_IDLE,HR_DIV,HR_UPDATE}.
//  Sub-module seq_divider: unsigned restoring divider, i_start/o_done, parameters NUM_W/DEN_W.
//  Window ring buffer, stats and FSM in this module.
// TESTING
//  rr=360 strobe -> o_hr_valid 17 cycles later, o_hr_bpm=60, min=max=60, o_avg_valid=0.
//  rr=233 -> bpm 92 (HR_ROUND_EN undefined) / 93 (defined); rr=288 -> 75 both.
//  8x rr=360 -> o_avg_valid=1, avg 60; then rr=180 (120 bpm) -> avg 67, max 120, min 60.
//  rr=50 and rr=2000 -> o_rr_invalid each, no o_hr_valid, stats unchanged.
//  Second strobe 5 cycles after first -> o_drop, exactly one o_hr_valid with first result.
//  i_clr 5 cycles into DIV -> no o_hr_valid; avg/max 0, min all ones, o_avg_valid 0.
//  i_nrst pulse 3 cycles into DIV -> same as reset; i_ce=0 strobe -> nothing happens.

Source files
------------

// File: rtl/alg_pkg.sv
//==============================================================================
// Module : alg_pkg
// Brief  : Shared constants and types for the RR / heart-rate processing path.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package alg_pkg;

    localparam int CTR_WIDTH        = 32;
    localparam int ACQUISITION_RATE = 360;
    localparam int HR_WIDTH         = 9;
    localparam int HR_NAVG          = 8;
    localparam int RR_MIN           = 72;
    localparam int RR_MAX           = 1080;

    typedef logic [HR_WIDTH-1:0] hr_value;

    typedef enum logic [1:0] {
        HR_IDLE   = 2'd0,
        HR_DIV    = 2'd1,
        HR_UPDATE = 2'd2
    } hr_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_hr_monitor_seq_divider.sv
//==============================================================================
// Module : seq_divider
// Brief  : Unsigned restoring divider, one quotient bit per clock, NUM_W steps.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module seq_divider #(
    parameter int NUM_W = 15,
    parameter int DEN_W = 11
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic [NUM_W-1:0] o_quot,
    output logic             o_done
);

    localparam int c_cnt_w = $clog2(NUM_W + 1);

    logic [NUM_W-1:0]   r_num;
    logic [DEN_W-1:0]   r_rem;
    logic [DEN_W-1:0]   r_den;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [DEN_W:0]     w_trial;
    logic [DEN_W-1:0]   w_diff;
    logic               w_fit;

    // Remainder stays below the divisor, so only the trial value needs the extra bit.
    assign w_trial = {r_rem, r_num[NUM_W-1]};
    assign w_fit   = (w_trial >= {1'b0, r_den});
    assign w_diff  = w_trial[DEN_W-1:0] - r_den;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_num  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_num  <= i_num;
                r_den  <= i_den;
                r_rem  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_fit ? w_diff : w_trial[DEN_W-1:0];
                r_num <= {r_num[NUM_W-2:0], w_fit};
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(NUM_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quot = r_num;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/rr_hr_monitor.sv
//==============================================================================
// Module : rr_hr_monitor
// Brief  : Converts RR periods to bpm, keeps moving average and min/max.
//          Define HR_ROUND_EN to round the bpm result to nearest.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rr_hr_monitor #(
    parameter int CTR_WIDTH        = alg_pkg::CTR_WIDTH,
    parameter int ACQUISITION_RATE = alg_pkg::ACQUISITION_RATE,
    parameter int HR_WIDTH         = alg_pkg::HR_WIDTH,
    parameter int HR_NAVG          = alg_pkg::HR_NAVG,
    parameter int RR_MIN           = alg_pkg::RR_MIN,
    parameter int RR_MAX           = alg_pkg::RR_MAX
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ce,
    input  logic                 i_clr,
    input  logic [CTR_WIDTH-1:0] i_rr_period,
    input  logic                 i_rr_period_upd,
    output logic [HR_WIDTH-1:0]  o_hr_bpm,
    output logic                 o_hr_valid,
    output logic [HR_WIDTH-1:0]  o_hr_avg,
    output logic                 o_avg_valid,
    output logic [HR_WIDTH-1:0]  o_hr_min,
    output logic [HR_WIDTH-1:0]  o_hr_max,
    output logic                 o_busy,
    output logic                 o_rr_invalid,
    output logic                 o_drop
);

    import alg_pkg::*;

    localparam int c_hr_k   = 60 * ACQUISITION_RATE;
    localparam int c_num_w  = $clog2(c_hr_k + RR_MAX / 2 + 1);
    localparam int c_den_w  = $clog2(RR_MAX + 1);
    localparam int c_avg_sh = $clog2(HR_NAVG);
    localparam int c_sum_w  = HR_WIDTH + c_avg_sh;
    localparam int c_ptr_w  = c_avg_sh;
    localparam int c_fill_w = $clog2(HR_NAVG + 1);

    hr_state_t             r_state;
    logic [HR_WIDTH-1:0]   r_win [HR_NAVG];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_sum_w-1:0]    r_sum;
    logic [c_fill_w-1:0]   r_fill;
    logic [HR_WIDTH-1:0]   r_hr_bpm;
    logic [HR_WIDTH-1:0]   r_hr_avg;
    logic [HR_WIDTH-1:0]   r_hr_min;
    logic [HR_WIDTH-1:0]   r_hr_max;
    logic                  r_hr_valid;
    logic                  r_avg_valid;
    logic                  r_rr_invalid;
    logic                  r_drop;

    logic                  w_rr_ok;
    logic                  w_start;
    logic [c_den_w-1:0]    w_den;
    logic [c_num_w-1:0]    w_num;
    logic [c_num_w-1:0]    w_quot;
    logic                  w_div_done;
    logic [HR_WIDTH-1:0]   w_bpm;
    logic [HR_WIDTH-1:0]   w_evict;
    logic [c_sum_w-1:0]    w_sum_new;
    logic [c_fill_w-1:0]   w_fill_new;

    assign w_rr_ok = (i_rr_period >= CTR_WIDTH'(RR_MIN)) && (i_rr_period <= CTR_WIDTH'(RR_MAX));
    assign w_den   = i_rr_period[c_den_w-1:0];
    assign w_start = (r_state == HR_IDLE) && i_rr_period_upd && i_ce && w_rr_ok && !i_clr;

`ifdef HR_ROUND_EN
    assign w_num = c_num_w'(c_hr_k) + c_num_w'(w_den >> 1);
`else
    assign w_num = c_num_w'(c_hr_k);
`endif

    seq_divider #(
        .NUM_W (c_num_w),
        .DEN_W (c_den_w)
    ) u_div (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_start (w_start),
        .i_abort (i_clr),
        .i_num   (w_num),
        .i_den   (w_den),
        .o_quot  (w_quot),
        .o_done  (w_div_done)
    );

    // Range check keeps the quotient within HR_WIDTH; saturate defensively anyway.
    assign w_bpm      = (|w_quot[c_num_w-1:HR_WIDTH]) ? '1 : w_quot[HR_WIDTH-1:0];
    assign w_evict    = r_win[r_wr_ptr];
    assign w_sum_new  = r_sum + c_sum_w'(w_bpm) - c_sum_w'(w_evict);
    assign w_fill_new = (r_fill == c_fill_w'(HR_NAVG)) ? r_fill : r_fill + c_fill_w'(1);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state      <= HR_IDLE;
            for (int i = 0; i < HR_NAVG; i++) r_win[i] <= '0;
            r_wr_ptr     <= '0;
            r_sum        <= '0;
            r_fill       <= '0;
            r_hr_bpm     <= '0;
            r_hr_avg     <= '0;
            r_hr_min     <= '1;
            r_hr_max     <= '0;
            r_hr_valid   <= 1'b0;
            r_avg_valid  <= 1'b0;
            r_rr_invalid <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_hr_valid   <= 1'b0;
            r_rr_invalid <= 1'b0;
            r_drop       <= 1'b0;
            if (i_clr) begin
                // Last bpm is deliberately kept; everything statistical restarts.
                r_state     <= HR_IDLE;
                for (int i = 0; i < HR_NAVG; i++) r_win[i] <= '0;
                r_wr_ptr    <= '0;
                r_sum       <= '0;
                r_fill      <= '0;
                r_hr_avg    <= '0;
                r_hr_min    <= '1;
                r_hr_max    <= '0;
                r_avg_valid <= 1'b0;
            end else begin
                case (r_state)
                    HR_IDLE: begin
                        if (i_rr_period_upd && i_ce) begin
                            if (w_rr_ok) r_state      <= HR_DIV;
                            else         r_rr_invalid <= 1'b1;
                        end
                    end
                    HR_DIV: begin
                        if (i_rr_period_upd) r_drop  <= 1'b1;
                        if (w_div_done)      r_state <= HR_UPDATE;
                    end
                    HR_UPDATE: begin
                        if (i_rr_period_upd) r_drop <= 1'b1;
                        r_hr_bpm         <= w_bpm;
                        r_hr_valid       <= 1'b1;
                        r_win[r_wr_ptr]  <= w_bpm;
                        r_wr_ptr         <= r_wr_ptr + c_ptr_w'(1);
                        r_sum            <= w_sum_new;
                        r_fill           <= w_fill_new;
                        if (w_bpm < r_hr_min) r_hr_min <= w_bpm;
                        if (w_bpm > r_hr_max) r_hr_max <= w_bpm;
                        if (w_fill_new == c_fill_w'(HR_NAVG)) begin
                            r_avg_valid <= 1'b1;
                            r_hr_avg    <= w_sum_new[c_sum_w-1 -: HR_WIDTH];
                        end
                        r_state <= HR_IDLE;
                    end
                    default: r_state <= HR_IDLE;
                endcase
            end
        end
    end

    assign o_hr_bpm     = r_hr_bpm;
    assign o_hr_valid   = r_hr_valid;
    assign o_hr_avg     = r_hr_avg;
    assign o_avg_valid  = r_avg_valid;
    assign o_hr_min     = r_hr_min;
    assign o_hr_max     = r_hr_max;
    assign o_busy       = (r_state != HR_IDLE);
    assign o_rr_invalid = r_rr_invalid;
    assign o_drop       = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_rr_hr_monitor.sv
//==============================================================================
// Module : tb_rr_hr_monitor
// Brief  : Directed self-checking bench for rr_hr_monitor (honours HR_ROUND_EN).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_rr_hr_monitor;

`ifdef HR_ROUND_EN
    localparam int c_bpm233 = 93;
`else
    localparam int c_bpm233 = 92;
`endif
    localparam int c_lat = 17;

    logic        clk;
    logic        nrst;
    logic        ce;
    logic        clr;
    logic [31:0] rr_period;
    logic        rr_upd;
    logic [8:0]  hr_bpm;
    logic        hr_valid;
    logic [8:0]  hr_avg;
    logic        avg_valid;
    logic [8:0]  hr_min;
    logic [8:0]  hr_max;
    logic        busy;
    logic        rr_invalid;
    logic        drop;

    int n_total = 0;
    int n_pass  = 0;

    rr_hr_monitor dut (
        .i_clk           (clk),
        .i_nrst          (nrst),
        .i_ce            (ce),
        .i_clr           (clr),
        .i_rr_period     (rr_period),
        .i_rr_period_upd (rr_upd),
        .o_hr_bpm        (hr_bpm),
        .o_hr_valid      (hr_valid),
        .o_hr_avg        (hr_avg),
        .o_avg_valid     (avg_valid),
        .o_hr_min        (hr_min),
        .o_hr_max        (hr_max),
        .o_busy          (busy),
        .o_rr_invalid    (rr_invalid),
        .o_drop          (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rr;
        bit clr_before;
        int bpm;
        int mn;
        int mx;
        int avg;
        bit av;
    } vec_t;

    vec_t tv [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pulse_strobe(input int rr);
        rr_period = rr;
        rr_upd    = 1'b1;
        tick();
        rr_upd    = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Strobe one rr and report cycles until o_hr_valid (-1 on timeout) and bpm then.
    task automatic beat(input int rr, output int lat, output int bpm);
        pulse_strobe(rr);
        lat = -1;
        bpm = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (hr_valid) begin
                lat = k;
                bpm = int'(hr_bpm);
                break;
            end
        end
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (hr_valid) cnt++;
        end
    endtask

    initial begin
        int lat, bpm, cnt;

        tv[0]  = '{360,  1'b0, 60,       60, 60,       0,  1'b0};
        tv[1]  = '{233,  1'b0, c_bpm233, 60, c_bpm233, 0,  1'b0};
        tv[2]  = '{288,  1'b0, 75,       60, c_bpm233, 0,  1'b0};
        for (int i = 3; i < 10; i++)
            tv[i] = '{360, (i == 3), 60, 60, 60, 0, 1'b0};
        tv[10] = '{360,  1'b0, 60,       60, 60,       60, 1'b1};
        tv[11] = '{180,  1'b0, 120,      60, 120,      67, 1'b1};
        tv[12] = '{72,   1'b0, 300,      60, 300,      97, 1'b1};
        tv[13] = '{1080, 1'b0, 20,       20, 300,      92, 1'b1};

        nrst = 1'b0; ce = 1'b1; clr = 1'b0; rr_period = '0; rr_upd = 1'b0;
        repeat (3) tick();
        check("reset bpm",       int'(hr_bpm),    0);
        check("reset min",       int'(hr_min),    511);
        check("reset max",       int'(hr_max),    0);
        check("reset avg_valid", int'(avg_valid), 0);
        check("reset busy",      int'(busy),      0);
        nrst = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            if (tv[i].clr_before) do_clear();
            beat(tv[i].rr, lat, bpm);
            check($sformatf("vec%0d latency", i), lat, c_lat);
            check($sformatf("vec%0d bpm", i),     bpm, tv[i].bpm);
            check($sformatf("vec%0d min", i),     int'(hr_min),    tv[i].mn);
            check($sformatf("vec%0d max", i),     int'(hr_max),    tv[i].mx);
            check($sformatf("vec%0d avg", i),     int'(hr_avg),    tv[i].avg);
            check($sformatf("vec%0d avg_valid", i), int'(avg_valid), int'(tv[i].av));
        end

        // Out-of-range periods: flagged, no result, stats untouched.
        pulse_strobe(50);
        check("inv50 flag", int'(rr_invalid), 1);
        check("inv50 busy", int'(busy), 0);
        count_valid(25, cnt);
        check("inv50 no valid", cnt, 0);
        pulse_strobe(2000);
        check("inv2000 flag", int'(rr_invalid), 1);
        count_valid(25, cnt);
        check("inv2000 no valid", cnt, 0);
        check("inv min", int'(hr_min), 20);
        check("inv max", int'(hr_max), 300);
        check("inv avg", int'(hr_avg), 92);

        // Second strobe while dividing is dropped; first result survives.
        pulse_strobe(360);
        repeat (4) tick();
        pulse_strobe(288);
        check("drop flag", int'(drop), 1);
        lat = -1;
        cnt = 0;
        bpm = -1;
        for (int k = 6; k <= 40; k++) begin
            tick();
            if (hr_valid) begin
                cnt++;
                if (lat < 0) begin
                    lat = k;
                    bpm = int'(hr_bpm);
                end
            end
        end
        check("drop valid count", cnt, 1);
        check("drop latency", lat, c_lat);
        check("drop bpm", bpm, 60);

        // Clear (with a simultaneous strobe) mid-division aborts the result.
        pulse_strobe(288);
        repeat (4) tick();
        clr = 1'b1; rr_upd = 1'b1; rr_period = 360;
        tick();
        clr = 1'b0; rr_upd = 1'b0;
        check("clr drop", int'(drop), 0);
        check("clr busy", int'(busy), 0);
        count_valid(30, cnt);
        check("clr no valid", cnt, 0);
        check("clr avg", int'(hr_avg), 0);
        check("clr max", int'(hr_max), 0);
        check("clr min", int'(hr_min), 511);
        check("clr avg_valid", int'(avg_valid), 0);
        check("clr bpm kept", int'(hr_bpm), 60);

        // Asynchronous reset mid-division.
        beat(360, lat, bpm);
        check("pre-rst bpm", bpm, 60);
        pulse_strobe(288);
        repeat (3) tick();
        #2 nrst = 1'b0;
        #1;
        check("arst bpm",  int'(hr_bpm), 0);
        check("arst min",  int'(hr_min), 511);
        check("arst max",  int'(hr_max), 0);
        check("arst busy", int'(busy),   0);
        tick();
        nrst = 1'b1;
        count_valid(30, cnt);
        check("arst no valid", cnt, 0);

        // Strobe with enable low is ignored.
        ce = 1'b0;
        pulse_strobe(360);
        check("ce0 busy", int'(busy), 0);
        check("ce0 invalid", int'(rr_invalid), 0);
        count_valid(25, cnt);
        check("ce0 no valid", cnt, 0);
        check("ce0 bpm", int'(hr_bpm), 0);
        ce = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
